genius_input_conditioner: RTL

GENIUS_INPUT_CONDITIONER -- requirements
Module: genius_input_conditioner

---
 rtl/genius_input_conditioner.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/genius_input_conditioner.sv
// Input conditioner for the Genius memory game: synchronizes and debounces
// three colour buttons plus start, and hands single qualified presses
// downstream through a valid/ack holding register.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   btn_raw[2:0]   raw asynchronous colour buttons (bit i = number i)
//   start_raw      raw asynchronous start button
//   press_ack      downstream consumed the held press
//   press_valid    a qualified press is held in press_code
//   press_code     held press number (0..2)
//   start_pulse    one-cycle pulse per debounced start press
//   btn_level      debounced button levels
//   press_multi    one-cycle pulse when several buttons rose together
//   press_overrun  sticky flag: a press was dropped while one was held
//
// Build option: define GENIUS_BTN_ACTIVE_LOW_EN for boards whose keys read
// 0 when pressed; the raw inputs are then inverted ahead of the synchronizer.
module genius_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] btn_raw,
  input  logic       start_raw,
  input  logic       press_ack,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic       start_pulse,
  output logic [2:0] btn_level,
  output logic       press_multi,
  output logic       press_overrun
);

  localparam int CW = 16;
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

  // Channel 3 is start, channels 2..0 are the colour buttons.
  logic [3:0] raw_in;

`ifdef GENIUS_BTN_ACTIVE_LOW_EN
  assign raw_in = ~{start_raw, btn_raw};
`else
  assign raw_in = {start_raw, btn_raw};
`endif

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    level;
  logic [3:0]    level_d;
  logic [3:0]    rise;
  logic [CW-1:0] cnt [4];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      rise    <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= raw_in;
      sync2   <= sync1;
      level_d <= level;
      // Rise flag lands the cycle after the debounced level goes high.
      rise    <= level & ~level_d;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LIMIT) begin
          level[i] <= ~level[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [2:0] btn_rise;
  logic       single;
  logic [1:0] idx;
  logic       valid_n;
  logic [1:0] code_n;
  logic       over_n;
  logic       multi_n;

  assign btn_rise = rise[2:0];

  always_comb begin
    single  = 1'b0;
    idx     = 2'b00;
    valid_n = press_valid;
    code_n  = press_code;
    over_n  = press_overrun;
    multi_n = 1'b0;
    case (btn_rise)
      3'b001: begin
        single = 1'b1;
        idx    = 2'd0;
      end
      3'b010: begin
        single = 1'b1;
        idx    = 2'd1;
      end
      3'b100: begin
        single = 1'b1;
        idx    = 2'd2;
      end
      default: begin
        single = 1'b0;
        idx    = 2'd0;
      end
    endcase
    if (single) begin
      // An ack in the same cycle frees the slot for the new press.
      if (!press_valid || press_ack) begin
        valid_n = 1'b1;
        code_n  = idx;
      end else begin
        over_n = 1'b1;
      end
    end else begin
      multi_n = ($countones(btn_rise) > 1);
      if (press_valid && press_ack) begin
        valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      press_valid   <= 1'b0;
      press_code    <= 2'b00;
      press_multi   <= 1'b0;
      press_overrun <= 1'b0;
    end else begin
      press_valid   <= valid_n;
      press_code    <= code_n;
      press_multi   <= multi_n;
      press_overrun <= over_n;
    end
  end

  assign start_pulse = rise[3];
  assign btn_level   = level[2:0];

endmodule
